dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer that shares the single-port DMEM between requester A (CPU datapath) and requester B (loader/debug port).
- Registers each winning request, drives the DMEM write/read strobes for exactly one cycle, and captures the read data.
- Returns a one-cycle acknowledge to the winning requester.
- Sits between the CPU and loader on one side and the DMEM instance on the other.

---
 rtl/dmem_arbiter_if.sv | 45 ++++
 rtl/dmem_arbiter.sv | 102 ++++++++++
 tb/tb_dmem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester A/B handshake and DMEM bus shared by the arbiter, its requesters and DMEM.
// `DMEM_ARB_PROTECT_EN adds the port-B write-protect error flag ARB_b_err.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              ARB_a_req, ARB_a_we, ARB_a_ack;
  logic [ADDR_W-1:0] ARB_a_addr;
  logic [DATA_W-1:0] ARB_a_wdata, ARB_a_rdata;
  logic              ARB_b_req, ARB_b_we, ARB_b_ack;
  logic [ADDR_W-1:0] ARB_b_addr;
  logic [DATA_W-1:0] ARB_b_wdata, ARB_b_rdata;
  logic [ADDR_W-1:0] ARB_mem_address;
  logic [DATA_W-1:0] ARB_mem_data_in, ARB_mem_data_out;
  logic              ARB_mem_write, ARB_mem_read, ARB_busy;
`ifdef DMEM_ARB_PROTECT_EN
  logic              ARB_b_err;
`endif

  // arbiter side
  modport slave (
`ifdef DMEM_ARB_PROTECT_EN
    output ARB_b_err,
`endif
    input  ARB_a_req, ARB_a_we, ARB_a_addr, ARB_a_wdata,
    output ARB_a_ack, ARB_a_rdata,
    input  ARB_b_req, ARB_b_we, ARB_b_addr, ARB_b_wdata,
    output ARB_b_ack, ARB_b_rdata,
    output ARB_mem_address, ARB_mem_data_in, ARB_mem_write, ARB_mem_read, ARB_busy,
    input  ARB_mem_data_out
  );

  // requesters + DMEM side
  modport master (
`ifdef DMEM_ARB_PROTECT_EN
    input  ARB_b_err,
`endif
    output ARB_a_req, ARB_a_we, ARB_a_addr, ARB_a_wdata,
    input  ARB_a_ack, ARB_a_rdata,
    output ARB_b_req, ARB_b_we, ARB_b_addr, ARB_b_wdata,
    input  ARB_b_ack, ARB_b_rdata,
    input  ARB_mem_address, ARB_mem_data_in, ARB_mem_write, ARB_mem_read, ARB_busy,
    output ARB_mem_data_out
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port DMEM arbiter/sequencer: IDLE -> ACCESS (one strobe cycle) -> RESP (one ack cycle).
// `DMEM_ARB_PROTECT_EN blocks port-B writes at or above PROTECT_BASE and pulses ARB_b_err.
module dmem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0
`ifdef DMEM_ARB_PROTECT_EN
  ,
  parameter logic [ADDR_W-1:0] PROTECT_BASE = 8'hC0
`endif
) (
  input logic           ARB_clk,
  input logic           ARB_rst,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;

  state_t            r_state, w_next;
  logic              r_cmd_b, r_cmd_we, r_last;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [DATA_W-1:0] r_cmd_wdata, r_a_rdata, r_b_rdata;
  logic              w_any, w_grant_b, w_wr_block;

  assign w_any = bus.ARB_a_req | bus.ARB_b_req;
  // r_last: 0 = A, 1 = B. B wins alone, or on a round-robin tie after A's turn.
  assign w_grant_b = bus.ARB_b_req & (~bus.ARB_a_req | ((PRIO_MODE == 0) && !r_last));

`ifdef DMEM_ARB_PROTECT_EN
  assign w_wr_block    = r_cmd_b & r_cmd_we & (r_cmd_addr >= PROTECT_BASE);
  assign bus.ARB_b_err = (r_state == S_RESP) & w_wr_block;
`else
  assign w_wr_block    = 1'b0;
`endif

  always_ff @(posedge ARB_clk) begin
    if (ARB_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge ARB_clk) begin
    if (ARB_rst) begin
      r_cmd_b     <= 1'b0;
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_last      <= 1'b1;
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_cmd_b     <= w_grant_b;
          r_cmd_we    <= w_grant_b ? bus.ARB_b_we    : bus.ARB_a_we;
          r_cmd_addr  <= w_grant_b ? bus.ARB_b_addr  : bus.ARB_a_addr;
          r_cmd_wdata <= w_grant_b ? bus.ARB_b_wdata : bus.ARB_a_wdata;
        end
        S_ACCESS: if (!r_cmd_we) begin
          if (r_cmd_b) r_b_rdata <= bus.ARB_mem_data_out;
          else         r_a_rdata <= bus.ARB_mem_data_out;
        end
        S_RESP:  r_last <= r_cmd_b;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      default:  w_next = S_IDLE;
    endcase
  end

  // Strobes are gated by reset so a write caught mid-ACCESS never lands.
  always_comb begin
    bus.ARB_mem_address = '0;
    bus.ARB_mem_data_in = '0;
    bus.ARB_mem_write   = 1'b0;
    bus.ARB_mem_read    = 1'b0;
    bus.ARB_a_ack       = 1'b0;
    bus.ARB_b_ack       = 1'b0;
    case (r_state)
      S_ACCESS: begin
        bus.ARB_mem_address = r_cmd_addr;
        bus.ARB_mem_data_in = r_cmd_wdata;
        bus.ARB_mem_write   = r_cmd_we & ~w_wr_block & ~ARB_rst;
        bus.ARB_mem_read    = ~r_cmd_we & ~ARB_rst;
      end
      S_RESP: begin
        bus.ARB_a_ack = ~r_cmd_b;
        bus.ARB_b_ack = r_cmd_b;
      end
      default: ;
    endcase
  end

  assign bus.ARB_busy    = (r_state != S_IDLE);
  assign bus.ARB_a_rdata = r_a_rdata;
  assign bus.ARB_b_rdata = r_b_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: round-robin and fixed-priority instances, each with a DMEM model,
// checked against a grant-order / memory-content reference kept in the bench.
module tb_dmem_arbiter;
  localparam int AW = 8, DW = 32;

  logic clk = 1'b0, rst = 1'b1, tb_load = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_rr ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_fp ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0)) u_rr (.ARB_clk(clk), .ARB_rst(rst), .bus(bus_rr.slave));
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1)) u_fp (.ARB_clk(clk), .ARB_rst(rst), .bus(bus_fp.slave));

  logic [DW-1:0] mem_rr [0:255];
  logic [DW-1:0] mem_fp [0:255];
  logic [DW-1:0] exp_mem [0:255];
  int n_chk = 0, n_fail = 0;

  function automatic logic [DW-1:0] pat(input int i);
    return (i * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // DMEM models: synchronous write, combinational read that is zero unless read is strobed
  always @(posedge clk) begin
    if (tb_load) for (int i = 0; i < 256; i++) mem_rr[i] <= pat(i);
    else if (bus_rr.ARB_mem_write) mem_rr[bus_rr.ARB_mem_address] <= bus_rr.ARB_mem_data_in;
  end
  always @(posedge clk) if (bus_fp.ARB_mem_write) mem_fp[bus_fp.ARB_mem_address] <= bus_fp.ARB_mem_data_in;
  assign bus_rr.ARB_mem_data_out = bus_rr.ARB_mem_read ? mem_rr[bus_rr.ARB_mem_address] : '0;
  assign bus_fp.ARB_mem_data_out = bus_fp.ARB_mem_read ? mem_fp[bus_fp.ARB_mem_address] : '0;

  // Bus invariants every cycle: exclusive strobes, strobes only while busy, one ack at a time
  always @(negedge clk) begin
    if (!rst) begin
      n_chk++;
      if ((bus_rr.ARB_mem_write && bus_rr.ARB_mem_read) || (bus_rr.ARB_a_ack && bus_rr.ARB_b_ack) ||
          ((bus_rr.ARB_mem_write || bus_rr.ARB_mem_read) && !bus_rr.ARB_busy)) begin
        n_fail++;
        $display("FAIL rr_bus_invariant: wr=%b rd=%b busy=%b acks=%b%b required exclusive strobes/acks", bus_rr.ARB_mem_write,
                 bus_rr.ARB_mem_read, bus_rr.ARB_busy, bus_rr.ARB_a_ack, bus_rr.ARB_b_ack);
      end
      n_chk++;
      if ((bus_fp.ARB_mem_write && bus_fp.ARB_mem_read) || (bus_fp.ARB_a_ack && bus_fp.ARB_b_ack) ||
          ((bus_fp.ARB_mem_write || bus_fp.ARB_mem_read) && !bus_fp.ARB_busy)) begin
        n_fail++;
        $display("FAIL fp_bus_invariant: wr=%b rd=%b busy=%b acks=%b%b required exclusive strobes/acks", bus_fp.ARB_mem_write,
                 bus_fp.ARB_mem_read, bus_fp.ARB_busy, bus_fp.ARB_a_ack, bus_fp.ARB_b_ack);
      end
    end
  end

  // requester-side view of the round-robin instance, index 0 = A, 1 = B
  bit            rq  [2];
  bit            rwe [2];
  logic [AW-1:0] rad [2];
  logic [DW-1:0] rwd [2];

  task automatic drive_rr();
    bus_rr.ARB_a_req = rq[0]; bus_rr.ARB_a_we = rwe[0]; bus_rr.ARB_a_addr = rad[0]; bus_rr.ARB_a_wdata = rwd[0];
    bus_rr.ARB_b_req = rq[1]; bus_rr.ARB_b_we = rwe[1]; bus_rr.ARB_b_addr = rad[1]; bus_rr.ARB_b_wdata = rwd[1];
  endtask

  task automatic new_fields(input int p);
    rwe[p] = 1'($urandom_range(0, 1));
    rad[p] = 8'($urandom_range(8'hBC, 8'hC7));
    rwd[p] = $urandom;
  endtask

  function automatic bit prot(input int p, input logic [AW-1:0] a, input bit we);
`ifdef DMEM_ARB_PROTECT_EN
    return (p == 1) && we && (a >= 8'hC0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_reset();
    rq[0] = 0; rq[1] = 0; drive_rr();
    bus_fp.ARB_a_req = 0; bus_fp.ARB_b_req = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_chk++;
    if ({bus_rr.ARB_a_ack, bus_rr.ARB_b_ack, bus_rr.ARB_mem_write, bus_rr.ARB_mem_read, bus_rr.ARB_busy,
         bus_rr.ARB_mem_address, bus_rr.ARB_mem_data_in, bus_rr.ARB_a_rdata, bus_rr.ARB_b_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_rr: outputs not all zero after reset");
    end
    n_chk++;
    if ({bus_fp.ARB_a_ack, bus_fp.ARB_b_ack, bus_fp.ARB_mem_write, bus_fp.ARB_mem_read, bus_fp.ARB_busy,
         bus_fp.ARB_mem_address, bus_fp.ARB_mem_data_in, bus_fp.ARB_a_rdata, bus_fp.ARB_b_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_fp: outputs not all zero after reset");
    end
  endtask

  // A write then A read of 8'h10; masks record per-cycle activity after the request is presented
  task automatic test_write_read();
    logic [3:0] wr_m, rd_m, aack_m,back_m;
    logic [AW-1:0] wr_addr; logic [DW-1:0] wr_data, rdat;
    for (int pass = 0; pass < 2; pass++) begin
      rq[0] = 1; rwe[0] = (pass == 0); rad[0] = 8'h10; rwd[0] = 32'hDEADBEEF; drive_rr();
      wr_m = 0; rd_m = 0; aack_m = 0; back_m = 0; wr_addr = 0; wr_data = 0; rdat = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        wr_m[c] = bus_rr.ARB_mem_write; rd_m[c] = bus_rr.ARB_mem_read;
        aack_m[c] = bus_rr.ARB_a_ack; back_m[c] = bus_rr.ARB_b_ack;
        if (bus_rr.ARB_mem_write) begin wr_addr = bus_rr.ARB_mem_address; wr_data = bus_rr.ARB_mem_data_in; end
        if (bus_rr.ARB_a_ack) begin rdat = bus_rr.ARB_a_rdata; rq[0] = 0; drive_rr(); end
      end
      n_chk++;
      if (aack_m !== 4'b0010 || back_m !== 4'b0000) begin
        n_fail++; $display("FAIL ack_timing pass%0d: a=%b b=%b required a=0010 b=0000", pass, aack_m, back_m);
      end
      if (pass == 0) begin
        exp_mem[8'h10] = 32'hDEADBEEF;
        n_chk++;
        if (wr_m !== 4'b0001 || rd_m !== 4'b0000) begin
          n_fail++; $display("FAIL write_strobe: wr=%b rd=%b required wr=0001 rd=0000", wr_m, rd_m);
        end
        n_chk++;
        if (wr_addr !== 8'h10 || wr_data !== 32'hDEADBEEF) begin
          n_fail++; $display("FAIL write_bus: addr=%h data=%h required 10/deadbeef", wr_addr, wr_data);
        end
      end else begin
        n_chk++;
        if (rd_m !== 4'b0001 || wr_m !== 4'b0000) begin
          n_fail++; $display("FAIL read_strobe: rd=%b wr=%b required rd=0001 wr=0000", rd_m, wr_m);
        end
        n_chk++;
        if (rdat !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data: got %h required deadbeef", rdat); end
      end
    end
  endtask

  // Both ports keep requesting (new command presented at each ack); grants must alternate A,B,...
  task automatic test_rr_fair();
    int got = 0, p, exp_p; bit m_last = 1; logic [1:0] ack, prev = 0; logic [5:0] order = 0; logic [DW-1:0] rd;
    do_reset();
    rq[0] = 1; rq[1] = 1; new_fields(0); new_fields(1); drive_rr();
    for (int c = 0; c < 60 && got < 6; c++) begin
      @(negedge clk);
      ack = {bus_rr.ARB_b_ack, bus_rr.ARB_a_ack};
      if (ack != 0) begin
        exp_p = m_last ? 0 : 1;
        p = bus_rr.ARB_b_ack ? 1 : 0;
        n_chk++;
        if (ack !== (2'b01 << exp_p)) begin n_fail++; $display("FAIL rr_grant: acks=%b required port %0d", ack, exp_p); end
        n_chk++;
        if (prev != 0) begin n_fail++; $display("FAIL rr_ack_width: ack %b on consecutive cycles, required one cycle", ack); end
        order[got] = p[0]; got++;
        if (rwe[p]) begin
          if (!prot(p, rad[p], 1'b1)) exp_mem[rad[p]] = rwd[p];
`ifdef DMEM_ARB_PROTECT_EN
          n_chk++;
          if (bus_rr.ARB_b_err !== prot(p, rad[p], 1'b1)) begin
            n_fail++; $display("FAIL rr_err: b_err=%b port %0d addr %h", bus_rr.ARB_b_err, p, rad[p]);
          end
`endif
        end else begin
          rd = p ? bus_rr.ARB_b_rdata : bus_rr.ARB_a_rdata;
          n_chk++;
          if (rd !== exp_mem[rad[p]]) begin
            n_fail++; $display("FAIL rr_rdata: port %0d addr %h got %h required %h", p, rad[p], rd, exp_mem[rad[p]]);
          end
        end
        m_last = p[0];
        new_fields(p); drive_rr();
      end
      prev = ack;
    end
    rq[0] = 0; rq[1] = 0; drive_rr();
    repeat (3) @(negedge clk);
    n_chk++;
    if (got != 6 || order !== 6'b101010) begin
      n_fail++; $display("FAIL rr_order: %0d grants, order(bit0 first)=%b required 6 grants 101010", got, order);
    end
  endtask

  // Random request mixes; each round waits until every requesting port is acked
  task automatic test_random();
    int p, exp_p, budget; bit m_last = 1; logic [DW-1:0] rd;
    do_reset();
    for (int r = 0; r < 40; r++) begin
      rq[0] = 1'($urandom_range(0, 1)); rq[1] = 1'($urandom_range(0, 1));
      if (!rq[0] && !rq[1]) rq[$urandom_range(0, 1)] = 1;
      new_fields(0); new_fields(1); drive_rr();
      budget = 0;
      while ((rq[0] || rq[1]) && budget < 20) begin
        @(negedge clk); budget++;
        if (bus_rr.ARB_a_ack || bus_rr.ARB_b_ack) begin
          exp_p = (rq[0] && rq[1]) ? (m_last ? 0 : 1) : (rq[1] ? 1 : 0);
          p = bus_rr.ARB_b_ack ? 1 : 0;
          n_chk++;
          if ({bus_rr.ARB_b_ack, bus_rr.ARB_a_ack} !== (2'b01 << exp_p)) begin
            n_fail++; $display("FAIL rand_grant r%0d: acks=%b%b required port %0d", r, bus_rr.ARB_b_ack, bus_rr.ARB_a_ack, exp_p);
          end
          if (rwe[p]) begin
            if (!prot(p, rad[p], 1'b1)) exp_mem[rad[p]] = rwd[p];
`ifdef DMEM_ARB_PROTECT_EN
            n_chk++;
            if (bus_rr.ARB_b_err !== prot(p, rad[p], 1'b1)) begin
              n_fail++; $display("FAIL rand_err r%0d: b_err=%b port %0d addr %h", r, bus_rr.ARB_b_err, p, rad[p]);
            end
`endif
          end else begin
            rd = p ? bus_rr.ARB_b_rdata : bus_rr.ARB_a_rdata;
            n_chk++;
            if (rd !== exp_mem[rad[p]]) begin
              n_fail++; $display("FAIL rand_rdata r%0d: port %0d addr %h got %h required %h", r, p, rad[p], rd, exp_mem[rad[p]]);
            end
          end
          m_last = p[0];
          rq[p] = 0; drive_rr();
        end
      end
      n_chk++;
      if (rq[0] || rq[1]) begin
        n_fail++; $display("FAIL rand_timeout r%0d: pending a=%b b=%b required none", r, rq[0], rq[1]);
        rq[0] = 0; rq[1] = 0; drive_rr(); do_reset();
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    for (int a = 8'hBC; a <= 8'hC7; a++) begin
      n_chk++;
      if (mem_rr[a] !== exp_mem[a]) begin
        n_fail++; $display("FAIL rand_mem addr %h: got %h required %h", a, mem_rr[a], exp_mem[a]);
      end
    end
  endtask

  // Reset lands while an A write to 8'h20 is in ACCESS: write and ack must both vanish
  task automatic test_reset_mid();
    logic [DW-1:0] old = exp_mem[8'h20]; int acks = 0;
    do_reset();
    rq[0] = 1; rwe[0] = 1; rad[0] = 8'h20; rwd[0] = ~old; drive_rr();
    @(negedge clk);
    rst = 1'b1; rq[0] = 0; drive_rr();
    #1;
    n_chk++;
    if (bus_rr.ARB_mem_write !== 1'b0) begin n_fail++; $display("FAIL rstmid_strobe: wr=%b required 0 under reset", bus_rr.ARB_mem_write); end
    @(negedge clk);
    n_chk++;
    if ({bus_rr.ARB_a_ack, bus_rr.ARB_b_ack, bus_rr.ARB_mem_write, bus_rr.ARB_mem_read, bus_rr.ARB_busy,
         bus_rr.ARB_mem_address, bus_rr.ARB_mem_data_in} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: busy=%b addr=%h required all zero", bus_rr.ARB_busy, bus_rr.ARB_mem_address);
    end
    rst = 1'b0;
    repeat (4) begin @(negedge clk); if (bus_rr.ARB_a_ack || bus_rr.ARB_b_ack) acks++; end
    n_chk++;
    if (acks != 0) begin n_fail++; $display("FAIL rstmid_ack: %0d acks required 0", acks); end
    n_chk++;
    if (mem_rr[8'h20] !== old) begin n_fail++; $display("FAIL rstmid_mem: got %h required %h", mem_rr[8'h20], old); end
  endtask

  // Fixed priority: A wins three times while B waits; B gets the first IDLE after A drops
  task automatic test_fixed_prio();
    int na = 0, drop_c = 0; bit done = 0;
    do_reset();
    bus_fp.ARB_a_req = 1; bus_fp.ARB_a_we = 1; bus_fp.ARB_a_addr = 8'($urandom); bus_fp.ARB_a_wdata = $urandom;
    bus_fp.ARB_b_req = 1; bus_fp.ARB_b_we = 0; bus_fp.ARB_b_addr = 8'h00; bus_fp.ARB_b_wdata = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus_fp.ARB_a_ack || bus_fp.ARB_b_ack) begin
        n_chk++;
        if (na < 3) begin
          if (!(bus_fp.ARB_a_ack && !bus_fp.ARB_b_ack)) begin
            n_fail++; $display("FAIL fp_a_wins #%0d: acks a=%b b=%b required A", na, bus_fp.ARB_a_ack, bus_fp.ARB_b_ack);
          end
          na++;
          if (na == 3) begin bus_fp.ARB_a_req = 0; drop_c = c; end
          else begin bus_fp.ARB_a_addr = 8'($urandom); bus_fp.ARB_a_wdata = $urandom; end
        end else begin
          if (!(bus_fp.ARB_b_ack && !bus_fp.ARB_a_ack) || (c - drop_c) != 3) begin
            n_fail++; $display("FAIL fp_b_after_drop: b=%b %0d cycles after A drop, required B at 3", bus_fp.ARB_b_ack, c - drop_c);
          end
          bus_fp.ARB_b_req = 0; done = 1;
        end
      end
    end
    n_chk++;
    if (!done) begin n_fail++; $display("FAIL fp_timeout: A grants %0d, B never granted", na); end
    bus_fp.ARB_a_req = 0; bus_fp.ARB_b_req = 0;
  endtask

`ifdef DMEM_ARB_PROTECT_EN
  task automatic test_protect();
    int wr_seen = 0; bit acked = 0, err_ok = 0; logic [DW-1:0] rdat = 0, old = exp_mem[8'hC4];
    do_reset();
    rq[1] = 1; rwe[1] = 1; rad[1] = 8'hC4; rwd[1] = 32'h1; drive_rr();
    for (int c = 0; c < 8 && !acked; c++) begin
      @(negedge clk);
      if (bus_rr.ARB_mem_write) wr_seen++;
      if (bus_rr.ARB_b_ack) begin acked = 1; err_ok = bus_rr.ARB_b_err; rq[1] = 0; drive_rr(); end
    end
    n_chk++;
    if (wr_seen != 0 || !acked) begin n_fail++; $display("FAIL prot_write: %0d write strobes ack=%b required 0 strobes, ack", wr_seen, acked); end
    n_chk++;
    if (err_ok !== 1'b1) begin n_fail++; $display("FAIL prot_err: b_err=%b with ack required 1", err_ok); end
    @(negedge clk);
    rq[1] = 1; rwe[1] = 0; drive_rr(); acked = 0;
    for (int c = 0; c < 8 && !acked; c++) begin
      @(negedge clk);
      if (bus_rr.ARB_b_ack) begin acked = 1; rdat = bus_rr.ARB_b_rdata; err_ok = bus_rr.ARB_b_err; rq[1] = 0; drive_rr(); end
    end
    n_chk++;
    if (!acked || rdat !== old || err_ok !== 1'b0) begin
      n_fail++; $display("FAIL prot_readback: got %h err=%b required %h err=0", rdat, err_ok, old);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = pat(i);
    rq[0] = 0; rq[1] = 0; rwe[0] = 0; rwe[1] = 0; rad[0] = 0; rad[1] = 0; rwd[0] = 0; rwd[1] = 0; drive_rr();
    bus_fp.ARB_a_req = 0; bus_fp.ARB_a_we = 0; bus_fp.ARB_a_addr = 0; bus_fp.ARB_a_wdata = 0;
    bus_fp.ARB_b_req = 0; bus_fp.ARB_b_we = 0; bus_fp.ARB_b_addr = 0; bus_fp.ARB_b_wdata = 0;
    @(negedge clk); @(negedge clk);
    tb_load = 1'b0;
    test_reset();
    test_write_read();
    test_rr_fair();
    test_random();
    test_reset_mid();
    test_fixed_prio();
`ifdef DMEM_ARB_PROTECT_EN
    test_protect();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
